// File: rtl/i2s_adc_receiver_pkg.sv
// Shared types for the I2S ADC receiver.
//   DATA_W     : default sample width in bits
//   sample_t   : one two's-complement audio sample
//   rx_state_e : frame-alignment FSM states
//   stereo_t   : one left/right sample pair
package audio_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ALIGN   = 3'd0,
    SHIFT_L = 3'd1,
    WAIT_R  = 3'd2,
    SHIFT_R = 3'd3,
    WAIT_L  = 3'd4
  } rx_state_e;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

endpackage

// File: rtl/i2s_adc_receiver_if.sv
// Parallel stereo-pair handshake between the I2S receiver and its consumer.
//   i_ready : consumer accepts the pair this cycle
//   o_left  : left sample
//   o_right : right sample
//   o_valid : pair available
// Handshake: a pair transfers on a rising clock edge where o_valid && i_ready.
// Once o_valid is high, o_left/o_right hold steady until that transfer; o_valid
// does not depend combinationally on i_ready.
interface i2s_adc_receiver_if #(
  parameter int DATA_W = audio_pkg::DATA_W
) ();

  logic              i_ready;
  logic [DATA_W-1:0] o_left;
  logic [DATA_W-1:0] o_right;
  logic              o_valid;

  // master = receiver (produces pairs), slave = downstream consumer
  modport master (output o_left, output o_right, output o_valid, input i_ready);
  modport slave  (input o_left, input o_right, input o_valid, output i_ready);

endinterface

// File: rtl/i2s_adc_receiver_slot_shifter.sv
// Per-slot bit counter and MSB-first shift register.
//   i_clk, i_rst_n : bit clock, async active-low reset
//   i_edge         : an LRC edge is seen this cycle (restarts the slot)
//   i_adcdat       : serial data bit for this cycle
//   o_word_done    : this cycle carries the last bit of the word
//   o_word         : assembled word including this cycle's bit
module i2s_slot_shifter #(
  parameter int DATA_W    = 16,
  parameter int I2S_DELAY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_edge,
  input  logic              i_adcdat,
  output logic              o_word_done,
  output logic [DATA_W-1:0] o_word
);

  localparam int KW = $clog2(DATA_W + I2S_DELAY + 1);
  localparam logic [KW-1:0] K_LAST = KW'(I2S_DELAY + DATA_W - 1);
  localparam logic [KW-1:0] K_SAT  = KW'(DATA_W + I2S_DELAY);

  logic [KW-1:0]     k_q;
  logic [KW-1:0]     k_cur;
  logic [DATA_W-1:0] shreg_q;
  logic              capture;

  // The edge cycle itself is bit index 0; k_q holds the index of the next cycle.
  assign k_cur = i_edge ? '0 : k_q;

  if (I2S_DELAY == 0) begin : g_lj
    assign capture = (k_cur <= K_LAST);
  end else begin : g_i2s
    assign capture = (k_cur >= KW'(I2S_DELAY)) && (k_cur <= K_LAST);
  end

  assign o_word_done = (k_cur == K_LAST);
  assign o_word      = {shreg_q[DATA_W-2:0], i_adcdat};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q     <= '0;
      shreg_q <= '0;
    end else begin
      k_q <= (k_cur == K_SAT) ? K_SAT : k_cur + KW'(1);
      if (capture) shreg_q <= o_word;
    end
  end

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S / left-justified ADC stream deserialiser with a valid/ready pair output.
//   i_clk, i_rst_n : codec bit clock, async active-low reset
//   i_lrc          : LR clock (low = left slot, high = right slot)
//   i_adcdat       : serial ADC data
//   pair_if        : stereo pair handshake (master side)
//   o_overrun      : sticky, a completed pair was dropped
//   o_sync_err     : sticky, an LRC edge broke a word or came with wrong polarity
//   o_pair_cnt     : pairs handed off, wraps
//   o_state        : alignment FSM state, for observation
module i2s_adc_receiver #(
  parameter int DATA_W    = audio_pkg::DATA_W,
  parameter int I2S_DELAY = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lrc,
  input  logic                i_adcdat,
  i2s_adc_receiver_if.master  pair_if,
  output logic                o_overrun,
  output logic                o_sync_err,
  output logic [15:0]         o_pair_cnt,
  output audio_pkg::rx_state_e o_state
);

  import audio_pkg::*;

  rx_state_e         state_q, state_d;
  logic              lrc_q;
  logic              lrc_edge, lrc_fall, lrc_rise;
  logic              word_done;
  logic [DATA_W-1:0] word;
  logic              latch_left, pair_done, sync_set;
  logic [DATA_W-1:0] left_hold_q;
  logic [DATA_W-1:0] left_q, right_q;
  logic              valid_q;
  logic              xfer;

  assign lrc_edge = i_lrc ^ lrc_q;
  assign lrc_fall = lrc_edge & ~i_lrc;
  assign lrc_rise = lrc_edge & i_lrc;

  i2s_slot_shifter #(
    .DATA_W   (DATA_W),
    .I2S_DELAY(I2S_DELAY)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_edge     (lrc_edge),
    .i_adcdat   (i_adcdat),
    .o_word_done(word_done),
    .o_word     (word)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ALIGN;
      lrc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lrc_q   <= i_lrc;
    end
  end

  // Next state. An edge can never coincide with word_done (the edge cycle is
  // bit 0), so edges are simply checked first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ALIGN:   if (lrc_fall) state_d = SHIFT_L;
      SHIFT_L: begin
        if (lrc_fall)       state_d = SHIFT_L;
        else if (lrc_rise)  state_d = ALIGN;
        else if (word_done) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (lrc_rise)      state_d = SHIFT_R;
        else if (lrc_fall) state_d = ALIGN;
      end
      SHIFT_R: begin
        if (lrc_fall)       state_d = SHIFT_L;
        else if (lrc_rise)  state_d = ALIGN;
        else if (word_done) state_d = WAIT_L;
      end
      WAIT_L: begin
        if (lrc_fall)      state_d = SHIFT_L;
        else if (lrc_rise) state_d = ALIGN;
      end
      default: state_d = ALIGN;
    endcase
  end

  // FSM outputs
  always_comb begin
    latch_left = (state_q == SHIFT_L) && !lrc_edge && word_done;
    pair_done  = (state_q == SHIFT_R) && !lrc_edge && word_done;
    sync_set   = (lrc_edge && (state_q == SHIFT_L || state_q == SHIFT_R))
              || (lrc_fall && state_q == WAIT_R)
              || (lrc_rise && state_q == WAIT_L);
  end

  assign xfer = valid_q && pair_if.i_ready;

  // Holding registers, handshake and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      o_overrun   <= 1'b0;
      o_sync_err  <= 1'b0;
      o_pair_cnt  <= '0;
    end else begin
      if (latch_left) left_hold_q <= word;
      // A completing pair is loaded only if the slot is free or being emptied
      // this cycle; otherwise the held pair wins and the new one is dropped.
      if (pair_done) begin
        if (!valid_q || pair_if.i_ready) begin
          left_q  <= left_hold_q;
          right_q <= word;
          valid_q <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      if (xfer)     o_pair_cnt <= o_pair_cnt + 16'd1;
      if (sync_set) o_sync_err <= 1'b1;
    end
  end

  assign pair_if.o_left  = left_q;
  assign pair_if.o_right = right_q;
  assign pair_if.o_valid = valid_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
module tb_i2s_adc_receiver;
  import audio_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic lrc0, dat0, lrc1, dat1;
  logic ov0, se0, ov1, se1;
  logic [15:0] cnt0, cnt1;
  rx_state_e st0, st1;

  i2s_adc_receiver_if #(.DATA_W(W)) bus0 ();
  i2s_adc_receiver_if #(.DATA_W(W)) bus1 ();

  // dut0: I2S mode, dut1: left-justified mode
  i2s_adc_receiver #(.DATA_W(W), .I2S_DELAY(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc0), .i_adcdat(dat0),
    .pair_if(bus0), .o_overrun(ov0), .o_sync_err(se0),
    .o_pair_cnt(cnt0), .o_state(st0)
  );

  i2s_adc_receiver #(.DATA_W(W), .I2S_DELAY(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc1), .i_adcdat(dat1),
    .pair_if(bus1), .o_overrun(ov1), .o_sync_err(se1),
    .o_pair_cnt(cnt1), .o_state(st1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2*W-1:0] exp_q0[$];
  logic [2*W-1:0] exp_q1[$];
  int   rises0 = 0, rises1 = 0;
  logic vprev0 = 1'b0, vprev1 = 1'b0;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    #3;
    if (bus0.o_valid && !vprev0) rises0++;
    vprev0 = bus0.o_valid;
    if (bus1.o_valid && !vprev1) rises1++;
    vprev1 = bus1.o_valid;
    if (bus0.o_valid && bus0.i_ready) begin
      tests_run++;
      if (exp_q0.size() == 0) begin
        tests_failed++;
        $display("FAIL sb0_unexpected got %h/%h required no pair", bus0.o_left, bus0.o_right);
      end else begin
        e = exp_q0.pop_front();
        if ({bus0.o_left, bus0.o_right} !== e) begin
          tests_failed++;
          $display("FAIL sb0_pair got %h/%h required %h/%h", bus0.o_left, bus0.o_right, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
    if (bus1.o_valid && bus1.i_ready) begin
      tests_run++;
      if (exp_q1.size() == 0) begin
        tests_failed++;
        $display("FAIL sb1_unexpected got %h/%h required no pair", bus1.o_left, bus1.o_right);
      end else begin
        e = exp_q1.pop_front();
        if ({bus1.o_left, bus1.o_right} !== e) begin
          tests_failed++;
          $display("FAIL sb1_pair got %h/%h required %h/%h", bus1.o_left, bus1.o_right, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Drive bit positions j0..j1-1 of one slot; word bits sit at delay..delay+W-1.
  task automatic drive_bits(input int sel, input logic ch, input logic [W-1:0] w,
                            input int delay, input int j0, input int j1);
    logic b;
    for (int j = j0; j < j1; j++) begin
      @(negedge clk);
      if (j >= delay && j < delay + W) b = w[W-1-(j-delay)];
      else                             b = 1'($urandom_range(0, 1));
      if (sel == 0) begin lrc0 = ch; dat0 = b; end
      else          begin lrc1 = ch; dat1 = b; end
    end
  endtask

  task automatic send_frame(input int sel, input logic [W-1:0] l, input logic [W-1:0] r,
                            input int slot, input bit push);
    int d;
    d = (sel == 0) ? 1 : 0;
    if (push) begin
      if (sel == 0) exp_q0.push_back({l, r});
      else          exp_q1.push_back({l, r});
    end
    drive_bits(sel, 1'b0, l, d, 0, slot);
    drive_bits(sel, 1'b1, r, d, 0, slot);
  endtask

  // A short right-slot stretch so the next frame begins with a falling edge.
  task automatic prime(input int sel);
    drive_bits(sel, 1'b1, '0, (sel == 0) ? 1 : 0, 0, 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lrc0 = 1'b1; dat0 = 1'b0; lrc1 = 1'b1; dat1 = 1'b0;
    bus0.i_ready = 1'b1; bus1.i_ready = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int sel, input int budget);
    int n;
    n = 0;
    while (((sel == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (((sel == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
      tests_failed++;
      $display("FAIL drain%0d got %0d pending required 0", sel,
               (sel == 0) ? exp_q0.size() : exp_q1.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lrc0 = 1'b1; dat0 = 1'b1; lrc1 = 1'b1; dat1 = 1'b1;
    bus0.i_ready = 1'b1; bus1.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus0.o_valid, bus0.o_left, bus0.o_right} !== '0) begin
      tests_failed++;
      $display("FAIL reset_out0 got %b/%h/%h required 0/0000/0000", bus0.o_valid, bus0.o_left, bus0.o_right);
    end
    tests_run++;
    if ({ov0, se0, cnt0} !== '0) begin
      tests_failed++;
      $display("FAIL reset_flags0 got ov=%b se=%b cnt=%0d required 0/0/0", ov0, se0, cnt0);
    end
    tests_run++;
    if (st0 !== ALIGN || st1 !== ALIGN) begin
      tests_failed++;
      $display("FAIL reset_state got %0d/%0d required %0d", st0, st1, ALIGN);
    end
    tests_run++;
    if ({bus1.o_valid, bus1.o_left, bus1.o_right, ov1, se1, cnt1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_out1 got v=%b %h/%h cnt=%0d required all 0", bus1.o_valid, bus1.o_left, bus1.o_right, cnt1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    prime(0);
    exp_q0.push_back({16'h8001, 16'h7FFE});
    drive_bits(0, 1'b0, 16'h8001, 1, 0, 32);
    drive_bits(0, 1'b1, 16'h7FFE, 1, 0, 17);  // through right bit 0 (LSB)
    @(negedge clk);
    tests_run++;
    if (bus0.o_valid !== 1'b1 || bus0.o_left !== 16'h8001 || bus0.o_right !== 16'h7FFE) begin
      tests_failed++;
      $display("FAIL basic_latency got v=%b %h/%h required 1 8001/7ffe", bus0.o_valid, bus0.o_left, bus0.o_right);
    end
    @(negedge clk);
    tests_run++;
    if (bus0.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse got v=%b required 0", bus0.o_valid);
    end
    drive_bits(0, 1'b1, 16'h7FFE, 1, 17, 32);
    wait_drain(0, 64);
    tests_run++;
    if (cnt0 !== 16'd1 || se0 !== 1'b0 || ov0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_flags got cnt=%0d se=%b ov=%b required 1/0/0", cnt0, se0, ov0);
    end
  endtask

  task automatic test_realign();
    @(negedge clk);
    rst_n = 1'b0; lrc0 = 1'b1;
    exp_q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_bits(0, 1'b1, W'($urandom), 1, 10, 32);  // tail of a right slot
    send_frame(0, 16'h5A5A, 16'hC3C3, 32, 1'b1);
    wait_drain(0, 64);
    tests_run++;
    if (se0 !== 1'b0 || cnt0 !== 16'd1) begin
      tests_failed++;
      $display("FAIL realign_flags got se=%b cnt=%0d required 0/1", se0, cnt0);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus0.i_ready = 1'b0;
    prime(0);
    send_frame(0, 16'hAAA1, 16'hAAA2, 32, 1'b1);
    send_frame(0, 16'hBBB1, 16'hBBB2, 32, 1'b0);
    send_frame(0, 16'hCCC1, 16'hCCC2, 32, 1'b0);
    tests_run++;
    if (bus0.o_valid !== 1'b1 || bus0.o_left !== 16'hAAA1 || bus0.o_right !== 16'hAAA2) begin
      tests_failed++;
      $display("FAIL overrun_hold got v=%b %h/%h required 1 aaa1/aaa2", bus0.o_valid, bus0.o_left, bus0.o_right);
    end
    tests_run++;
    if (ov0 !== 1'b1 || cnt0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL overrun_flag got ov=%b cnt=%0d required 1/0", ov0, cnt0);
    end
    @(negedge clk);
    bus0.i_ready = 1'b1;
    wait_drain(0, 16);
    tests_run++;
    if (cnt0 !== 16'd1 || bus0.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_release got cnt=%0d v=%b required 1/0", cnt0, bus0.o_valid);
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    prime(0);
    drive_bits(0, 1'b0, 16'h1111, 1, 0, 32);
    drive_bits(0, 1'b1, 16'h2222, 1, 0, 10);  // LRC falls early
    send_frame(0, 16'h1234, 16'hABCD, 32, 1'b1);
    wait_drain(0, 64);
    tests_run++;
    if (se0 !== 1'b1 || cnt0 !== 16'd1 || ov0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_err got se=%b cnt=%0d ov=%b required 1/1/0", se0, cnt0, ov0);
    end
  endtask

  task automatic test_left_justified();
    do_reset();
    prime(1);
    send_frame(1, 16'hFFFF, 16'h0000, 32, 1'b1);
    wait_drain(1, 64);
    tests_run++;
    if (cnt1 !== 16'd1) begin
      tests_failed++;
      $display("FAIL lj_count got %0d required 1", cnt1);
    end
  endtask

  task automatic test_back_to_back();
    rises1 = 0;
    for (int i = 0; i < 6; i++)
      send_frame(1, W'($urandom), W'($urandom), 16, 1'b1);
    wait_drain(1, 64);
    tests_run++;
    if (rises1 !== 6 || cnt1 !== 16'd7) begin
      tests_failed++;
      $display("FAIL b2b_pulses got rises=%0d cnt=%0d required 6/7", rises1, cnt1);
    end
    tests_run++;
    if (se1 !== 1'b0 || ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_flags got se=%b ov=%b required 0/0", se1, ov1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    prime(0);
    send_frame(0, 16'h0F0F, 16'hF0F0, 32, 1'b1);
    bus0.i_ready = 1'b0;
    send_frame(0, 16'h1357, 16'h2468, 32, 1'b1);   // left held
    drive_bits(0, 1'b0, 16'h9999, 1, 0, 8);       // partway into SHIFT_L
    tests_run++;
    if (bus0.o_valid !== 1'b1 || cnt0 !== 16'd1 || st0 !== SHIFT_L) begin
      tests_failed++;
      $display("FAIL arst_pre got v=%b cnt=%0d st=%0d required 1/1/%0d", bus0.o_valid, cnt0, st0, SHIFT_L);
    end
    #2;
    rst_n = 1'b0;
    exp_q0.delete();
    #1;
    tests_run++;
    if ({bus0.o_valid, bus0.o_left, bus0.o_right, ov0, se0, cnt0} !== '0 || st0 !== ALIGN) begin
      tests_failed++;
      $display("FAIL arst_now got v=%b %h/%h cnt=%0d st=%0d required all 0", bus0.o_valid, bus0.o_left, bus0.o_right, cnt0, st0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus0.i_ready = 1'b1;
    drive_bits(0, 1'b0, 16'h9999, 1, 8, 32);
    drive_bits(0, 1'b1, 16'h7777, 1, 0, 32);
    tests_run++;
    if (bus0.o_valid !== 1'b0 || cnt0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL arst_quiet got v=%b cnt=%0d required 0/0", bus0.o_valid, cnt0);
    end
    send_frame(0, 16'h4321, 16'h8765, 32, 1'b1);
    wait_drain(0, 64);
    tests_run++;
    if (cnt0 !== 16'd1 || se0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_after got cnt=%0d se=%b required 1/0", cnt0, se0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lrc0 = 1'b1; dat0 = 1'b0; lrc1 = 1'b1; dat1 = 1'b0;
    bus0.i_ready = 1'b1; bus1.i_ready = 1'b1;
    test_reset();
    test_basic();
    test_realign();
    test_overrun();
    test_sync_err();
    test_left_justified();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
